// File: rtl/pixel_frame_sequencer_if.sv
// Row readout channel between the frame sequencer and the downstream frame buffer.
// The sequencer side drives the row enable, index and valid; the buffer answers with ready.
interface pixel_frame_sequencer_if #(
    parameter int ROW_BITS = 2
);
    logic                read;
    logic [ROW_BITS-1:0] row_sel;
    logic                row_valid;
    logic                row_ready;
    logic                frame_done;

    modport master (
        output read,
        output row_sel,
        output row_valid,
        output frame_done,
        input  row_ready
    );

    modport slave (
        input  read,
        input  row_sel,
        input  row_valid,
        input  frame_done,
        output row_ready
    );
endinterface

// File: rtl/pixel_frame_sequencer.sv
// Global-shutter frame controller: erase, expose, ramp conversion, then row-by-row readout.
// All outputs are registered and decode the state they belong to; timers are down-counters.
//
// state       | meaning
// ------------+--------------------------------------------------------------
// S_IDLE      | waiting for start; frame_done pulses here after the last row
// S_ERASE     | erase phase held for ERASE_CYCLES cycles
// S_EXPOSE    | expose phase held for the latched exposure
// S_CONVERT   | ramp enabled, counter sweeps 0 .. 2^PIXEL_BITS-1
// S_SETTLE    | read enabled, row data settling, row_valid low
// S_XFER      | row_valid high, waiting for row_ready
module pixel_frame_sequencer #(
    parameter int PIXEL_BITS   = 8,
    parameter int ROWS         = 4,
    parameter int ROW_BITS     = (ROWS > 1) ? $clog2(ROWS) : 1,
    parameter int ERASE_CYCLES = 5,
    parameter int READ_SETTLE  = 2
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  start_i,
    input  logic [PIXEL_BITS-1:0] expose_time_i,
    output logic                  busy_o,
    output logic                  erase_o,
    output logic                  expose_o,
    output logic                  convert_o,
    output logic [PIXEL_BITS-1:0] counter_o,
    pixel_frame_sequencer_if.master row_if
);

    localparam int TW_A = (PIXEL_BITS > $clog2(ERASE_CYCLES)) ? PIXEL_BITS : $clog2(ERASE_CYCLES);
    localparam int TW   = (TW_A > $clog2(READ_SETTLE + 1)) ? TW_A : $clog2(READ_SETTLE + 1);

    // Timers hold "cycles remaining minus one", so the terminal count is zero.
    localparam logic [TW-1:0] ERASE_LOAD  = TW'(ERASE_CYCLES - 1);
    localparam logic [TW-1:0] CONV_LOAD   = TW'((1 << PIXEL_BITS) - 1);
    localparam logic [TW-1:0] SETTLE_LOAD = TW'((READ_SETTLE > 0) ? READ_SETTLE - 1 : 0);
    localparam logic [ROW_BITS-1:0] LAST_ROW = ROW_BITS'(ROWS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ERASE,
        S_EXPOSE,
        S_CONVERT,
        S_SETTLE,
        S_XFER
    } state_t;

    state_t                state_q;
    logic [TW-1:0]         timer_q;
    logic [PIXEL_BITS-1:0] exp_q;
    logic                  busy_q;
    logic                  erase_q;
    logic                  expose_q;
    logic                  convert_q;
    logic [PIXEL_BITS-1:0] counter_q;
    logic                  read_q;
    logic [ROW_BITS-1:0]   row_sel_q;
    logic                  row_valid_q;
    logic                  frame_done_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q      <= S_IDLE;
            timer_q      <= '0;
            exp_q        <= PIXEL_BITS'(1);
            busy_q       <= 1'b0;
            erase_q      <= 1'b0;
            expose_q     <= 1'b0;
            convert_q    <= 1'b0;
            counter_q    <= '0;
            read_q       <= 1'b0;
            row_sel_q    <= '0;
            row_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        state_q <= S_ERASE;
                        timer_q <= ERASE_LOAD;
                        exp_q   <= (expose_time_i == '0) ? PIXEL_BITS'(1) : expose_time_i;
                        busy_q  <= 1'b1;
                        erase_q <= 1'b1;
                    end
                end
                S_ERASE: begin
                    if (timer_q == '0) begin
                        state_q  <= S_EXPOSE;
                        timer_q  <= TW'(exp_q) - TW'(1);
                        erase_q  <= 1'b0;
                        expose_q <= 1'b1;
                    end else begin
                        timer_q <= timer_q - TW'(1);
                    end
                end
                S_EXPOSE: begin
                    if (timer_q == '0) begin
                        state_q   <= S_CONVERT;
                        timer_q   <= CONV_LOAD;
                        expose_q  <= 1'b0;
                        convert_q <= 1'b1;
                        counter_q <= '0;
                    end else begin
                        timer_q <= timer_q - TW'(1);
                    end
                end
                S_CONVERT: begin
                    if (timer_q == '0) begin
                        // With no settle time the first row is valid straight away.
                        state_q     <= (READ_SETTLE == 0) ? S_XFER : S_SETTLE;
                        timer_q     <= SETTLE_LOAD;
                        convert_q   <= 1'b0;
                        counter_q   <= '0;
                        read_q      <= 1'b1;
                        row_sel_q   <= '0;
                        row_valid_q <= (READ_SETTLE == 0);
                    end else begin
                        timer_q   <= timer_q - TW'(1);
                        counter_q <= counter_q + PIXEL_BITS'(1);
                    end
                end
                S_SETTLE: begin
                    if (timer_q == '0) begin
                        state_q     <= S_XFER;
                        row_valid_q <= 1'b1;
                    end else begin
                        timer_q <= timer_q - TW'(1);
                    end
                end
                S_XFER: begin
                    if (row_if.row_ready) begin
                        if (row_sel_q == LAST_ROW) begin
                            state_q      <= S_IDLE;
                            busy_q       <= 1'b0;
                            read_q       <= 1'b0;
                            row_valid_q  <= 1'b0;
                            row_sel_q    <= '0;
                            frame_done_q <= 1'b1;
                        end else begin
                            state_q     <= (READ_SETTLE == 0) ? S_XFER : S_SETTLE;
                            timer_q     <= SETTLE_LOAD;
                            row_sel_q   <= row_sel_q + ROW_BITS'(1);
                            row_valid_q <= (READ_SETTLE == 0);
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy_o            = busy_q;
    assign erase_o           = erase_q;
    assign expose_o          = expose_q;
    assign convert_o         = convert_q;
    assign counter_o         = counter_q;
    assign row_if.read       = read_q;
    assign row_if.row_sel    = row_sel_q;
    assign row_if.row_valid  = row_valid_q;
    assign row_if.frame_done = frame_done_q;

endmodule

// File: doc/pixel_frame_sequencer.md
# pixel_frame_sequencer

Frame-level controller for the pixel array. One `start` runs one global-shutter frame. The block drives the shared ERASE/EXPOSE phase lines to every `PIXEL_ROW` instance, gates the ADC ramp and generates the shared digital conversion counter. It then reads the rows out one at a time over a valid/ready handshake to the downstream frame buffer.

## Interface
- `PIXEL_BITS`, 8: width of the conversion counter; conversion lasts 2^PIXEL_BITS cycles.
- `ROWS`, 4: number of pixel rows read out per frame (≥1).
- `ROW_BITS`, $clog2(ROWS) (min 1): width of `row_sel`.
- `ERASE_CYCLES`, 5: length of the erase phase in clock cycles (≥1).
- `READ_SETTLE`, 2: cycles `read` is held before `row_valid` asserts (≥0).

- `clk`  in  1  main clock; all logic on posedge.
- `reset`  in  1  synchronous, active-high; one clock; reset is synchronous and active-high.
- `start`  in  1  request one frame; sampled only in IDLE.
- `expose_time`  in  PIXEL_BITS  exposure length in cycles; latched when `start` is accepted; 0 is treated as 1.
- `row_ready`  in  1  downstream accepts the current row.
- `busy`  out  1  high in every state except IDLE.
- `erase`  out  1  pixel erase phase.
- `expose`  out  1  pixel expose phase.
- `convert`  out  1  ramp enable; the top level forms RAMP = convert ? clk : 0.
- `counter`  out  PIXEL_BITS  digital ramp shared by all rows.
- `read`  out  1  row readout enable (DATA_OUT of the selected row is driven).
- `row_sel`  out  ROW_BITS  index of the row being read.
- `row_valid`  out  1  `rowData` of `row_sel` is stable and may be captured.
- `frame_done`  out  1  one-cycle pulse after the last row handshake.

## Operation
- States: IDLE, ERASE, EXPOSE, CONVERT, READ_SETTLE, READ_XFER. The state register and all outputs are registered; outputs decode the current state, with no combinational path from inputs to outputs.
- IDLE:
  - All outputs are 0; `row_sel` = 0.
  - `start`=1 latches `expose_time` (0→1), clears the phase counter and moves to ERASE.
- ERASE: `erase`=1 for exactly ERASE_CYCLES cycles, then EXPOSE.
- EXPOSE: `expose`=1 for exactly the latched exposure cycles, then CONVERT.
- CONVERT:
  - `convert`=1 for exactly 2^PIXEL_BITS cycles.
  - `counter`=0 in the first CONVERT cycle and +1 each cycle, reaching 2^PIXEL_BITS−1 in the last. It never wraps inside CONVERT.
  - `counter`=0 in all other states.
  - Then READ_SETTLE with `row_sel`=0.
- READ_SETTLE: `read`=1, `row_valid`=0 for READ_SETTLE cycles, then READ_XFER. If READ_SETTLE=0 the state is skipped.
- READ_XFER:
  - `read`=1, `row_valid`=1, held until `row_ready`=1.
  - Handshake when `row_valid` && `row_ready` on a posedge.
  - Handshake on a row with `row_sel` < ROWS−1: `row_sel`+1, back to READ_SETTLE.
  - Handshake on `row_sel` = ROWS−1: go to IDLE, with `frame_done`=1 for the first IDLE cycle.
- `row_sel`, `read` and `row_valid` must not change while `row_valid`=1 and `row_ready`=0 (stall).
- `start` outside IDLE is ignored (not queued). `start` held high continuously gives back-to-back frames: IDLE lasts exactly one cycle between frames, and that cycle is also the `frame_done` cycle.
- `expose_time` changes after acceptance do not affect the running frame.
- Exactly one of `erase`/`expose`/`convert`/`read` is high at any time, or none.

## Timing
- Reset: state=IDLE. `busy`, `erase`, `expose`, `convert`, `read`, `row_valid`, `frame_done` = 0; `counter`=0; `row_sel`=0; latched exposure = 1.
- Reset mid-frame: on the next posedge all outputs take their reset values. No `frame_done` is produced and the frame is abandoned.
- Latency:
  - `start` sampled at edge N → `busy`=`erase`=1 from edge N+1.
  - `erase` falls and `expose` rises on the same edge.
  - All phase handoffs are gapless: no idle cycle between ERASE, EXPOSE, CONVERT and the first READ_SETTLE.
- Minimum frame length, with `row_ready` always high: ERASE_CYCLES + E + 2^PIXEL_BITS + ROWS·(READ_SETTLE+1) cycles of `busy`, where E is the latched exposure.
- `row_ready` high in READ_SETTLE has no effect.

## Test plan
- Reset then `start` pulse, `expose_time`=10, `row_ready`=1, defaults:
  - `erase` high 5 cycles, `expose` 10, `convert` 256 with `counter` 0..255.
  - 4 rows, each 2 `read`-only cycles then 1 `row_valid` cycle with `row_sel` 0,1,2,3.
  - `frame_done` pulses once.
  - `busy` high 5+10+256+12=283 cycles.
- `expose_time`=0 → `expose` high exactly 1 cycle; change `expose_time` to 200 mid-frame → still 1.
- Backpressure: hold `row_ready`=0 for 7 cycles at row 1 → `row_valid`=1 and `row_sel`=1 stable throughout; row 2 appears only after `row_ready` rises.
- `start` held high across 2 frames → `frame_done` and a 1-cycle IDLE between frames, then `erase` on the next cycle; `start` pulses inside a frame are ignored.
- Assert `reset` for 1 cycle during CONVERT at `counter`=100 → next cycle all outputs 0, `counter`=0, no `frame_done`; a fresh `start` runs a full frame.
- Every cycle of all runs: at most one of `erase`/`expose`/`convert`/`read` high; `counter`≠0 only while `convert`=1.
